// File: rtl/mips_core_mc.sv
// rtl/mips_core_mc.sv - multicycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT), big-endian byte lanes.
// Define MIPS_CORE_PERF_CNT_EN to add the cycle_cnt / instret_cnt outputs.
module mips_core_mc #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int NBYTES = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic [XLEN-1:0] inst_addr,
  input  logic [31:0]     inst,
  input  logic            inst_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic [7:0]      mem_data_out [0:NBYTES-1],
  output logic [7:0]      mem_data_in  [0:NBYTES-1],
  output logic            mem_write_en,
  output logic            mem_req,
  input  logic            mem_ready,
  output logic            halted
`ifdef MIPS_CORE_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
`endif
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SYSCALL = 6'h0c, FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2a;

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [0:31];
  logic [XLEN-1:0] a, b, res;

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, shamt, dest;
  logic            is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, is_syscall, is_alu, is_mem;
  logic [XLEN-1:0] imm_sext, pc4, br_target, j_target, alu_y, load_word;

  always_comb begin
    op         = ir[31:26];
    rs         = ir[25:21];
    rt         = ir[20:16];
    rd         = ir[15:11];
    shamt      = ir[10:6];
    funct      = ir[5:0];
    imm_sext   = {{(XLEN-16){ir[15]}}, ir[15:0]};
    pc4        = inst_addr + XLEN'(4);
    br_target  = pc4 + (imm_sext << 2);
    j_target   = {pc4[XLEN-1:28], ir[25:0], 2'b00};
    // Canonical R-type encodings only; a nonzero shamt field falls through to NOP.
    is_rtype   = (op == OP_RTYPE) && (shamt == 5'd0) &&
                 (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    is_syscall = (op == OP_RTYPE) && (funct == FN_SYSCALL);
    is_addi    = (op == OP_ADDI);
    is_lw      = (op == OP_LW);
    is_sw      = (op == OP_SW);
    is_beq     = (op == OP_BEQ);
    is_j       = (op == OP_J);
    is_alu     = is_rtype || is_addi;
    is_mem     = is_lw || is_sw;
    dest       = is_rtype ? rd : rt;

    alu_y = a + imm_sext;
    if (is_rtype) begin
      case (funct)
        FN_SUB:  alu_y = a - b;
        FN_AND:  alu_y = a & b;
        FN_OR:   alu_y = a | b;
        FN_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        default: alu_y = a + b;
      endcase
    end

    load_word = '0;
    for (int i = 0; i < NBYTES; i++) load_word[XLEN-1-8*i -: 8] = mem_data_out[i];
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state        <= FETCH;
      inst_addr    <= RESET_PC;
      halted       <= 1'b0;
      mem_req      <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      res          <= '0;
      for (int i = 0; i < NBYTES; i++) mem_data_in[i] <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: if (inst_ready) begin
          ir    <= inst;
          state <= DECODE;
        end
        DECODE: begin
          a     <= (rs == 5'd0) ? '0 : regs[rs];
          b     <= (rt == 5'd0) ? '0 : regs[rt];
          state <= EXEC;
        end
        EXEC: begin
          res <= alu_y;
          if (is_syscall) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (is_alu) begin
            state <= WB;
          end else if (is_mem) begin
            // Address, data and strobe are captured once here and held through the wait.
            state        <= MEM;
            mem_req      <= 1'b1;
            mem_write_en <= is_sw;
            mem_addr     <= a + imm_sext;
            for (int i = 0; i < NBYTES; i++) mem_data_in[i] <= b[XLEN-1-8*i -: 8];
          end else begin
            inst_addr <= is_j ? j_target : ((is_beq && (a == b)) ? br_target : pc4);
            state     <= FETCH;
          end
        end
        MEM: if (mem_ready) begin
          mem_req      <= 1'b0;
          mem_write_en <= 1'b0;
          res          <= load_word;
          if (is_sw) begin
            inst_addr <= pc4;
            state     <= FETCH;
          end else begin
            state <= WB;
          end
        end
        WB: begin
          if (dest != 5'd0) regs[dest] <= res;
          inst_addr <= pc4;
          state     <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

`ifdef MIPS_CORE_PERF_CNT_EN
  logic retire;
  assign retire = ((state == EXEC) && !is_alu && !is_mem && !is_syscall) ||
                  ((state == MEM) && mem_ready && is_sw) ||
                  (state == WB);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (!halted) cycle_cnt <= cycle_cnt + 64'd1;
      if (retire) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: doc/mips_core_mc.md
MIPS_CORE_MC -- requirements
Module: mips_core_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width; legal values are 32 or 64.
REQ-002 SHALL have parameter RESET_PC, default 0, inst_addr value after reset.
REQ-003 SHALL derive localparam NBYTES = XLEN/8, the memory byte-lane count.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_b  in  1  reset; synchronous and active-high.
REQ-006 SHALL have port inst_addr  out  XLEN  program counter.
REQ-007 SHALL have port inst  in  32  instruction word at inst_addr.
REQ-008 SHALL have port inst_ready  in  1  inst is valid this cycle.
REQ-009 SHALL have port mem_addr  out  XLEN  data address.
REQ-010 SHALL have port mem_data_out  in  8 x NBYTES (unpacked [0:NBYTES-1])  read data; lane 0 is the MSB (big-endian).
REQ-011 SHALL have port mem_data_in  out  8 x NBYTES  write data, same lane order.
REQ-012 SHALL have port mem_write_en  out  1  store strobe.
REQ-013 SHALL have port mem_req  out  1  data access request.
REQ-014 SHALL have port mem_ready  in  1  access complete.
REQ-015 SHALL have port halted  out  1  core stopped.

Function
REQ-016 SHALL be a multicycle FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-017 FETCH SHALL hold until inst_ready=1, then latch inst into IR and go to DECODE.
REQ-018 DECODE SHALL read rs/rt from a 32 x XLEN register file; register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-019 SHALL support ADD, SUB, AND, OR, SLT (R-type), ADDI, LW, SW, BEQ, J and SYSCALL; any other encoding SHALL execute as a NOP (PC+4).
REQ-020 Arithmetic SHALL wrap modulo 2^XLEN with no overflow trap.
REQ-021 Immediates SHALL be sign-extended to XLEN.
REQ-022 SLT SHALL compare signed operands.
REQ-023 BEQ target SHALL be PC+4+(sext(imm)<<2); J target SHALL be {PC+4[XLEN-1:28], idx, 2'b00}.
REQ-024 Cycle counts with inst_ready and mem_ready tied high SHALL be: R-type/ADDI 4 (F,D,E,WB); LW 5 (F,D,E,M,WB); SW 4 (F,D,E,M); BEQ/J/NOP 3 (F,D,E).
REQ-025 In MEM, mem_req SHALL be 1 and mem_addr = rs + sext(imm), with no alignment check and low bits passed unmodified.
REQ-026 In MEM, mem_write_en SHALL equal 1 for SW only; the FSM SHALL stay in MEM until mem_ready=1.
REQ-027 mem_addr, mem_data_in and mem_write_en SHALL remain stable while waiting in MEM.
REQ-028 mem_ready or inst_ready asserted while not awaited SHALL be ignored.
REQ-029 mem_req and mem_write_en SHALL be 0 in every state except MEM.
REQ-030 LW SHALL write the lane-assembled word to rt in WB.
REQ-031 SYSCALL SHALL enter HALT after EXEC; halted SHALL be 1 and HALT SHALL be absorbing until reset, with PC frozen at the SYSCALL address.
REQ-032 PC SHALL update only at the end of EXEC (non-memory ops), MEM (SW) or WB (LW, ALU).

Reset
REQ-033 While rst_b=1 at a clock edge: state=FETCH, PC=RESET_PC, halted=0, mem_req=0, mem_write_en=0, IR=0, and all registers=0.
REQ-034 Reset asserted during MEM wait SHALL deassert mem_req on the next edge with no register-file or PC update.

Configuration
REQ-035 Macro MIPS_CORE_PERF_CNT_EN, when defined, SHALL add output ports cycle_cnt (64 bits, counts every non-reset cycle while not halted) and instret_cnt (64 bits, +1 per retired instruction including NOPs, excluding SYSCALL); both SHALL reset to 0.
REQ-036 Without MIPS_CORE_PERF_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 ADDI $1,$0,5; ADDI $2,$0,-3; ADD $3,$1,$2; SYSCALL -> $3=2, halted=1 after 4+4+4+3=15 cycles, inst_addr=12.
REQ-038 SW $3,8($0) with mem_ready low 3 cycles -> mem_req=1 and mem_write_en=1 held for 4 cycles, mem_addr=8, mem_data_in lanes {00,00,00,02} (XLEN=32).
REQ-039 LW $4,8($0) with mem_data_out={DE,AD,BE,EF} -> $4=0xDEADBEEF; BEQ $4,$4,-1 -> PC returns to the BEQ address.
REQ-040 SLT $5,$2,$1 with $2=-3, $1=5 -> $5=1; ADDI $0,$0,7 -> $0 reads 0.
REQ-041 Assert rst_b mid-MEM wait -> next cycle mem_req=0, inst_addr=RESET_PC, registers=0.
REQ-042 With MIPS_CORE_PERF_CNT_EN, program of REQ-037 -> instret_cnt=3, cycle_cnt=15 at halt.
